// File: rtl/serial_out_if.sv
// ----------------------------------------------------------------------------
// serial_out_if
// Groups the control, RAM read port and serial stream signals of serial_out.
//
// Parameters
//   ADDR_WIDTH : RAM read address width
//   DATA_WIDTH : RAM record word width
//
// Signals
//   start, num_dp[11:0], feat[3:0]  : transmission request and its settings
//   rd_addr, rd_en, rd_data         : synchronous RAM read port (data one cycle after rd_en)
//   ser, ser_valid, last            : serial bit stream
//   busy, done                      : transmission status
//
// Modports
//   master : the serializer (drives rd_addr/rd_en, the stream and the status)
//   slave  : the environment (drives start/num_dp/feat, returns rd_data)
// ----------------------------------------------------------------------------
interface serial_out_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 256
);
   logic                  start;
   logic [11:0]           num_dp;
   logic [3:0]            feat;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  ser;
   logic                  ser_valid;
   logic                  last;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, num_dp, feat, rd_data,
      output rd_addr, rd_en, ser, ser_valid, last, busy, done
   );

   modport slave (
      output start, num_dp, feat, rd_data,
      input  rd_addr, rd_en, ser, ser_valid, last, busy, done
   );
endinterface

// File: rtl/serial_out.sv
// ----------------------------------------------------------------------------
// serial_out
// Reads num_dp records from a synchronous RAM and shifts the active fields of
// each record out one bit per cycle, LSB of the lowest active field first.
// A record holds MAX_FEATURES+1 fields of LENGTH bits; only the top feat+1
// fields are sent, so each record emits LENGTH*(feat+1) bits starting at
// index DATA_WIDTH-LENGTH*(feat+1) and ending at DATA_WIDTH-1.
// Every record is preceded by a two-cycle gap (FETCH, LOAD).
//
// Ports
//   CLK  : rising-edge clock
//   RST  : synchronous, active-high reset (aborts a transmission, no done)
//   bus  : serial_out_if.master (start/num_dp/feat in, RAM read port,
//          ser/ser_valid/last stream, busy/done status)
//
// Build option
//   SERIAL_OUT_PARITY_EN : when defined, one extra bit carrying the even
//   parity of the record's sent bits follows each record, and last moves to
//   that parity bit. Undefined (default): no parity bit.
//
// All outputs are registered; they are computed from the next-state values.
// ----------------------------------------------------------------------------
module serial_out #(
   parameter int ADDR_WIDTH   = 12,
   parameter int MAX_FEATURES = 15,
   parameter int LENGTH       = 16,
   parameter int DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1)
) (
   input  logic         CLK,
   input  logic         RST,
   serial_out_if.master bus
);

   localparam int IDX_W = 9;
   localparam int SEL_W = $clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_DW  = IDX_W'(DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LEN = IDX_W'(LENGTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      FIN   = 3'd4
   } state_t;

   // state and datapath registers
   state_t                state_r,   state_nxt;
   logic [11:0]           num_dp_r,  num_dp_nxt;
   logic [3:0]            feat_r,    feat_nxt;
   logic [ADDR_WIDTH-1:0] addr_r,    addr_nxt;
   logic [DATA_WIDTH-1:0] word_r,    word_nxt;
   logic [IDX_W-1:0]      idx_r,     idx_nxt;

   // registered outputs
   logic [ADDR_WIDTH-1:0] rd_addr_r,   rd_addr_nxt;
   logic                  rd_en_r,     rd_en_nxt;
   logic                  ser_r,       ser_nxt;
   logic                  ser_valid_r, ser_valid_nxt;
   logic                  last_r,      last_nxt;
   logic                  busy_r,      busy_nxt;
   logic                  done_r,      done_nxt;

   // helpers
   logic [IDX_W-1:0]      fld_cnt_s;
   logic [IDX_W-1:0]      base_s;
   logic [ADDR_WIDTH-1:0] last_addr_s;
   logic                  rec_end_s;
   logic                  final_bit_s;

`ifdef SERIAL_OUT_PARITY_EN
   logic                  par_acc_r,   par_acc_nxt;
   logic                  par_phase_r, par_phase_nxt;

   // Even parity of a bit stream is the running XOR of its bits.
   function automatic logic par_fold(input logic acc, input logic b);
      return acc ^ b;
   endfunction
`endif

   // First transmitted bit index and address of the final record.
   always_comb begin
      fld_cnt_s   = {5'd0, feat_r} + 9'd1;
      base_s      = IDX_DW - (fld_cnt_s * IDX_LEN);
      last_addr_s = ADDR_WIDTH'(num_dp_r - 12'd1);
   end

   // Next-state, datapath and next output values.
   always_comb begin
      state_nxt     = state_r;
      num_dp_nxt    = num_dp_r;
      feat_nxt      = feat_r;
      addr_nxt      = addr_r;
      word_nxt      = word_r;
      idx_nxt       = idx_r;
      rec_end_s     = 1'b0;
      final_bit_s   = 1'b0;
      rd_addr_nxt   = rd_addr_r;
      rd_en_nxt     = 1'b0;
      ser_nxt       = 1'b0;
      ser_valid_nxt = 1'b0;
      last_nxt      = 1'b0;
      busy_nxt      = 1'b0;
      done_nxt      = 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
      par_acc_nxt   = par_acc_r;
      par_phase_nxt = par_phase_r;
`endif

      case (state_r)
         IDLE: begin
            // Settings are captured only here, so later changes are ignored.
            if (bus.start) begin
               num_dp_nxt = bus.num_dp;
               feat_nxt   = bus.feat;
               addr_nxt   = '0;
               if (bus.num_dp == 12'd0) begin
                  state_nxt = FIN;
               end else begin
                  state_nxt = FETCH;
               end
            end else begin
               state_nxt = IDLE;
            end
         end

         FETCH: begin
            state_nxt = LOAD;
         end

         LOAD: begin
            // rd_data is valid now: one cycle after the FETCH read strobe.
            word_nxt  = bus.rd_data;
            idx_nxt   = base_s;
            state_nxt = SHIFT;
`ifdef SERIAL_OUT_PARITY_EN
            par_acc_nxt   = 1'b0;
            par_phase_nxt = 1'b0;
`endif
         end

         SHIFT: begin
`ifdef SERIAL_OUT_PARITY_EN
            // After the top data bit one extra cycle carries the parity bit.
            if (par_phase_r) begin
               par_phase_nxt = 1'b0;
               rec_end_s     = 1'b1;
            end else begin
               par_acc_nxt = par_fold(par_acc_r, word_r[idx_r[SEL_W-1:0]]);
               if (idx_r == IDX_TOP) begin
                  par_phase_nxt = 1'b1;
               end else begin
                  idx_nxt = idx_r + 9'd1;
               end
            end
`else
            if (idx_r == IDX_TOP) begin
               rec_end_s = 1'b1;
            end else begin
               idx_nxt = idx_r + 9'd1;
            end
`endif
            if (rec_end_s) begin
               if (addr_r == last_addr_s) begin
                  state_nxt = FIN;
               end else begin
                  addr_nxt  = addr_r + ADDR_WIDTH'(1);
                  state_nxt = FETCH;
               end
            end else begin
               state_nxt = SHIFT;
            end
         end

         FIN: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Final bit of the current record in the upcoming cycle.
`ifdef SERIAL_OUT_PARITY_EN
      final_bit_s = par_phase_nxt;
`else
      final_bit_s = (idx_nxt == IDX_TOP);
`endif

      // Outputs describe the state being entered, so they are registered.
      rd_en_nxt = (state_nxt == FETCH);
      if (rd_en_nxt) begin
         rd_addr_nxt = addr_nxt;
      end else begin
         rd_addr_nxt = rd_addr_r;
      end

      ser_valid_nxt = (state_nxt == SHIFT);
      if (ser_valid_nxt) begin
`ifdef SERIAL_OUT_PARITY_EN
         if (par_phase_nxt) begin
            ser_nxt = par_acc_nxt;
         end else begin
            ser_nxt = word_nxt[idx_nxt[SEL_W-1:0]];
         end
`else
         ser_nxt = word_nxt[idx_nxt[SEL_W-1:0]];
`endif
      end else begin
         ser_nxt = 1'b0;
      end

      last_nxt = ser_valid_nxt && final_bit_s && (addr_nxt == last_addr_s);
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == FIN);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= IDLE;
         num_dp_r    <= 12'd0;
         feat_r      <= 4'd0;
         addr_r      <= '0;
         word_r      <= '0;
         idx_r       <= 9'd0;
         rd_addr_r   <= '0;
         rd_en_r     <= 1'b0;
         ser_r       <= 1'b0;
         ser_valid_r <= 1'b0;
         last_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
`ifdef SERIAL_OUT_PARITY_EN
         par_acc_r   <= 1'b0;
         par_phase_r <= 1'b0;
`endif
      end else begin
         state_r     <= state_nxt;
         num_dp_r    <= num_dp_nxt;
         feat_r      <= feat_nxt;
         addr_r      <= addr_nxt;
         word_r      <= word_nxt;
         idx_r       <= idx_nxt;
         rd_addr_r   <= rd_addr_nxt;
         rd_en_r     <= rd_en_nxt;
         ser_r       <= ser_nxt;
         ser_valid_r <= ser_valid_nxt;
         last_r      <= last_nxt;
         busy_r      <= busy_nxt;
         done_r      <= done_nxt;
`ifdef SERIAL_OUT_PARITY_EN
         par_acc_r   <= par_acc_nxt;
         par_phase_r <= par_phase_nxt;
`endif
      end
   end

   assign bus.rd_addr   = rd_addr_r;
   assign bus.rd_en     = rd_en_r;
   assign bus.ser       = ser_r;
   assign bus.ser_valid = ser_valid_r;
   assign bus.last      = last_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

endmodule

// File: tb/tb_serial_out.sv
// ----------------------------------------------------------------------------
// tb_serial_out
// Directed bench for serial_out: reset state, single short record, two full
// records, empty transmission, reset abort and restart, start held high with
// settings changed mid-run. A small synchronous RAM model answers reads.
// Outputs are sampled on the falling edge; inputs change there too.
// ----------------------------------------------------------------------------
module tb_serial_out;

   localparam int AW = 12;
   localparam int DW = 256;
`ifdef SERIAL_OUT_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic CLK = 1'b0;
   logic RST;

   serial_out_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) sif ();

   serial_out #(
      .ADDR_WIDTH(AW), .MAX_FEATURES(15), .LENGTH(16), .DATA_WIDTH(DW)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(sif)
   );

   always #5 CLK = ~CLK;

   // RAM model: data one cycle after the read strobe
   logic [DW-1:0] mem [4];
   always @(posedge CLK) begin
      if (sif.rd_en) sif.rd_data <= mem[sif.rd_addr[1:0]];
   end

   int n_checks = 0;
   int n_bad    = 0;

   // observation state
   int            cyc;
   int            nbits;
   logic [1023:0] bits;
   int            n_last;
   int            last_pos;
   int            first_valid_cyc;
   int            last_valid_cyc;
   int            n_rden;
   logic [AW-1:0] rd_log [8];
   int            n_done;
   int            done_cyc;
   int            gap_cyc;
   int            bad_ser;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_stats();
      cyc = 0; nbits = 0; bits = '0; n_last = 0; last_pos = -1;
      first_valid_cyc = -1; last_valid_cyc = -1; n_rden = 0;
      n_done = 0; done_cyc = -1; gap_cyc = 0; bad_ser = 0;
      for (int i = 0; i < 8; i++) rd_log[i] = '0;
   endtask

   // Advance one cycle and record what the DUT shows on the falling edge.
   task automatic step();
      @(negedge CLK);
      cyc++;
      if (sif.ser_valid) begin
         if (nbits < 1024) bits[nbits] = sif.ser;
         if (first_valid_cyc < 0) first_valid_cyc = cyc;
         last_valid_cyc = cyc;
         if (sif.last) begin
            n_last++;
            last_pos = nbits;
         end
         nbits++;
      end else begin
         if (sif.ser) bad_ser++;
         if (sif.busy && !sif.done) gap_cyc++;
      end
      if (sif.rd_en) begin
         if (n_rden < 8) rd_log[n_rden] = sif.rd_addr;
         n_rden++;
      end
      if (sif.done) begin
         n_done++;
         done_cyc = cyc;
      end
   endtask

   task automatic wait_done(input int bound);
      for (int i = 0; i < bound && n_done == 0; i++) step();
      check_val("done_seen", 256'(n_done), 256'(1));
   endtask

   task automatic launch(input logic [11:0] n, input logic [3:0] f);
      clear_stats();
      sif.num_dp = n;
      sif.feat   = f;
      sif.start  = 1'b1;
      step();
      sif.start  = 1'b0;
   endtask

   initial begin
      mem[0] = {16'hA5C3, 16'h5A3C, 224'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_01234567_89ABCDEF_FEDCBA98};
      mem[1] = {8{32'h13579BDF}};
      mem[2] = {8{32'h2468ACE0}};
      mem[3] = {8{32'hFFFF0000}};
      sif.start  = 1'b0;
      sif.num_dp = 12'd0;
      sif.feat   = 4'd0;
      RST = 1'b1;
      clear_stats();
      step();
      step();

      // reset state
      check_val("rst_busy",      256'(sif.busy),      256'(0));
      check_val("rst_ser_valid", 256'(sif.ser_valid), 256'(0));
      check_val("rst_ser",       256'(sif.ser),       256'(0));
      check_val("rst_last",      256'(sif.last),      256'(0));
      check_val("rst_done",      256'(sif.done),      256'(0));
      check_val("rst_rd_en",     256'(sif.rd_en),     256'(0));
      check_val("rst_rd_addr",   256'(sif.rd_addr),   256'(0));
      RST = 1'b0;
      step();

      // single record, one field
      launch(12'd1, 4'd0);
      check_val("t1_busy",  256'(sif.busy),  256'(1));
      check_val("t1_rd_en", 256'(sif.rd_en), 256'(1));
      wait_done(100);
      repeat (3) step();
      check_val("t1_nbits",      256'(nbits),           256'(16 + PAR));
      check_val("t1_bits",       256'(bits[15:0]),      256'(16'hA5C3));
      check_val("t1_first_cyc",  256'(first_valid_cyc), 256'(3));
      check_val("t1_n_last",     256'(n_last),          256'(1));
      check_val("t1_last_pos",   256'(last_pos),        256'(15 + PAR));
      check_val("t1_done_cyc",   256'(done_cyc),        256'(19 + PAR));
      check_val("t1_n_done",     256'(n_done),          256'(1));
      check_val("t1_n_rden",     256'(n_rden),          256'(1));
      check_val("t1_rd_addr0",   256'(rd_log[0]),       256'(0));
      check_val("t1_idle_ser",   256'(bad_ser),         256'(0));
      check_val("t1_busy_end",   256'(sif.busy),        256'(0));
`ifdef SERIAL_OUT_PARITY_EN
      check_val("t1_parity",     256'(bits[16]),        256'(0));
`endif

      // two full records
      launch(12'd2, 4'd15);
      wait_done(1200);
      repeat (3) step();
      check_val("t2_nbits",    256'(nbits),               256'(512 + 2 * PAR));
      check_val("t2_rec0",     bits[255:0],               mem[0]);
      check_val("t2_rec1",     bits[256 + PAR +: 256],    mem[1]);
      check_val("t2_n_rden",   256'(n_rden),              256'(2));
      check_val("t2_rd_addr0", 256'(rd_log[0]),           256'(0));
      check_val("t2_rd_addr1", 256'(rd_log[1]),           256'(1));
      check_val("t2_gap",      256'(gap_cyc),             256'(4));
      check_val("t2_done_cyc", 256'(done_cyc),            256'(517 + 2 * PAR));
      check_val("t2_done_gap", 256'(done_cyc - last_valid_cyc), 256'(1));
      check_val("t2_n_last",   256'(n_last),              256'(1));
      check_val("t2_last_pos", 256'(last_pos),            256'(511 + 2 * PAR));
      check_val("t2_idle_ser", 256'(bad_ser),             256'(0));

      // empty transmission
      launch(12'd0, 4'd3);
      wait_done(20);
      repeat (3) step();
      check_val("t3_done_cyc", 256'(done_cyc), 256'(1));
      check_val("t3_n_rden",   256'(n_rden),   256'(0));
      check_val("t3_nbits",    256'(nbits),    256'(0));
      check_val("t3_n_done",   256'(n_done),   256'(1));

      // reset during bit 100 of record 0, then restart
      launch(12'd3, 4'd15);
      for (int i = 0; i < 2000 && nbits < 100; i++) step();
      check_val("t4_reached_bit100", 256'(nbits), 256'(100));
      RST = 1'b1;
      step();
      check_val("t4_busy",      256'(sif.busy),      256'(0));
      check_val("t4_ser_valid", 256'(sif.ser_valid), 256'(0));
      check_val("t4_done",      256'(sif.done),      256'(0));
      RST = 1'b0;
      repeat (5) step();
      check_val("t4_no_done",   256'(n_done),        256'(0));
      launch(12'd1, 4'd0);
      check_val("t4_restart_addr", 256'(sif.rd_addr), 256'(0));
      wait_done(100);
      check_val("t4_restart_bits", 256'(bits[15:0]), 256'(16'hA5C3));

      // start held high, settings changed while busy
      clear_stats();
      step();
      clear_stats();
      sif.num_dp = 12'd2;
      sif.feat   = 4'd3;
      sif.start  = 1'b1;
      for (int i = 0; i < 200 && nbits < 10; i++) step();
      sif.feat   = 4'd7;
      sif.num_dp = 12'd5;
      for (int i = 0; i < 1000 && n_done == 0; i++) step();
      sif.start  = 1'b0;
      repeat (4) step();
      check_val("t5_nbits",  256'(nbits),              256'(128 + 2 * PAR));
      check_val("t5_rec0",   256'(bits[63:0]),         256'(64'hA5C35A3C0F1E2D3C));
      check_val("t5_rec1",   256'(bits[64 + PAR +: 64]), 256'(64'h13579BDF13579BDF));
      check_val("t5_n_rden", 256'(n_rden),             256'(2));
      check_val("t5_n_done", 256'(n_done),             256'(1));
      check_val("t5_busy",   256'(sif.busy),           256'(0));

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_out.md
SERIAL_OUT -- requirements
Module: serial_out

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: width of the RAM read address.
REQ-002 Parameter MAX_FEATURES, default 15: maximum feature index per record.
REQ-003 Parameter LENGTH, default 16: bits per field.
REQ-004 Parameter DATA_WIDTH, default LENGTH*(MAX_FEATURES+1) = 256: record word width.
REQ-005 CLK  input  1: rising-edge clock.
REQ-006 RST  input  1: reset, synchronous, active-high.
REQ-007 start  input  1: begin transmission; sampled in IDLE only.
REQ-008 num_dp  input  12: number of records to send; latched on accepted start.
REQ-009 feat  input  4: feature count minus one; latched on accepted start.
REQ-010 rd_addr  output  ADDR_WIDTH: RAM read address.
REQ-011 rd_en  output  1: RAM read strobe.
REQ-012 rd_data  input  DATA_WIDTH: RAM read data, valid the cycle after rd_en.
REQ-013 ser  output  1: serial data bit.
REQ-014 ser_valid  output  1: ser carries a valid bit this cycle.
REQ-015 last  output  1: current bit is the final bit of the final record.
REQ-016 busy  output  1: transmission in progress.
REQ-017 done  output  1: one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, LOAD, SHIFT, FIN.
REQ-019 IDLE: start=1 latches num_dp/feat, clears addr counter to 0; goes to FIN if num_dp==0, else FETCH.
REQ-020 FETCH: rd_en=1 for exactly one cycle, rd_addr=addr counter; next state LOAD.
REQ-021 LOAD: captures rd_data into the shift register, sets bit index to base = DATA_WIDTH-16*(feat+1); next state SHIFT.
REQ-022 SHIFT: one bit per cycle, ser=word[index], ser_valid=1, index increments from base up to DATA_WIDTH-1 inclusive (ascending, LSB of active field first).
REQ-023 Each record SHALL emit exactly 16*(feat+1) bits; bits below base are never sent.
REQ-024 After index DATA_WIDTH-1: if addr counter == num_dp-1 go to FIN, else increment addr counter and go to FETCH.
REQ-025 Inter-record gap SHALL be exactly 2 cycles (FETCH, LOAD) with ser_valid=0.
REQ-026 FIN: done=1 for one cycle, then IDLE.
REQ-027 busy=1 in FETCH, LOAD, SHIFT, FIN; 0 in IDLE.
REQ-028 last=1 only with the final bit of record num_dp-1.
REQ-029 ser SHALL be 0 whenever ser_valid=0; rd_addr holds its last value when rd_en=0.
REQ-030 start while busy SHALL be ignored; num_dp/feat changes while busy have no effect.
REQ-031 Index arithmetic SHALL be 9 bits; addr counter ADDR_WIDTH bits; num_dp up to 4095 supported without wrap.

Reset
REQ-032 RST=1 at a clock edge SHALL force IDLE and zero shift register, index, addr counter, rd_addr, rd_en, ser, ser_valid, last, busy, done by the next cycle.
REQ-033 RST mid-transmission SHALL abort without done; the next start restarts at address 0.
REQ-034 RST has priority over start.

Configuration
REQ-035 Macro SERIAL_OUT_PARITY_EN defined: after the last data bit of each record one extra SHIFT cycle SHALL emit the even-parity bit (XOR of the record's sent bits) with ser_valid=1; last moves to that parity bit.
REQ-036 Macro undefined: no parity bit; each record is exactly 16*(feat+1) bits.

Verification
REQ-037 feat=0, num_dp=1, rd_data[255:240]=16'hA5C3 -> ser_valid 16 cycles, ser=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; last on 16th bit; done next cycle.
REQ-038 feat=15, num_dp=2 -> rd_en at addr 0 then 1, 512 valid bits, two 2-cycle gaps (start, mid), done one cycle after bit 512.
REQ-039 num_dp=0, start=1 -> rd_en never asserted, ser_valid never 1, done pulses in the cycle after start.
REQ-040 RST=1 during bit 100 of record 0 (feat=15, num_dp=3) -> next cycle busy=0, ser_valid=0, no done; new start fetches addr 0.
REQ-041 start held high through transmission, feat changed 3->7 mid-run -> record lengths stay 64 bits; one done only.
REQ-042 SERIAL_OUT_PARITY_EN defined, feat=0, data 16'hA5C3 -> 17 valid bits, 17th bit 0, last on 17th.
